// File: rtl/reg_file_multi_if.sv
// Bus-side signal bundle of the reg_file_multi register bank.
// The master drives the strobes and address; the slave returns read data and err.
interface reg_file_multi_if;
  logic [23:0] address;
  logic [31:0] data_in;
  logic        ws_n;
  logic        rs_n;
  logic [3:0]  be;
  logic        as;
  logic [31:0] data_out;
  logic        err;

  modport master (
    output address, data_in, ws_n, rs_n, be, as,
    input  data_out, err
  );

  modport slave (
    input  address, data_in, ws_n, rs_n, be, as,
    output data_out, err
  );
endinterface

// File: rtl/reg_file_multi.sv
// Register bank slave: NUM_LFSR Galois LFSR channels, CTRL, ACCESS_CNT and scratch words.
// A single access is taken per chip-select assertion; reads are registered.
module reg_file_multi #(
  parameter int          NUM_REGS      = 8,
  parameter int          ADDR_SEL_BITS = 3,
  parameter int          NUM_LFSR      = 2,
  parameter logic [31:0] LFSR_POLY     = 32'h80200003,
  parameter logic [31:0] LFSR_SEED     = 32'h00000001,
  parameter logic [31:0] RESET_DATA    = 32'hfee1dead
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_multi_if.slave bus
);
  localparam int CTRL_IDX = NUM_LFSR;
  localparam int CNT_IDX  = NUM_LFSR + 1;
  localparam int SCR_BASE = NUM_LFSR + 2;
  localparam int NUM_SCR  = NUM_REGS - SCR_BASE;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return (r >> 1) ^ ({32{r[0]}} & LFSR_POLY);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic                     rw_state_r;
  logic [31:0]              lfsr_r   [NUM_LFSR];
  logic [31:0]              lfsr_nx_s[NUM_LFSR];
  logic [NUM_LFSR-1:0]      ctrl_r, ctrl_nx_s;
  logic [31:0]              cnt_r, cnt_nx_s;
  logic [31:0]              scr_r   [NUM_SCR];
  logic [31:0]              scr_nx_s[NUM_SCR];
  logic [31:0]              data_out_r;
  logic                     err_r;
  logic [31:0]              rdata_s;
  logic [31:0]              mask_s;
  logic [ADDR_SEL_BITS-1:0] idx_s;
  logic                     start_s, rd_s, wr_s, in_range_s;

  assign bus.data_out = data_out_r;
  assign bus.err      = err_r;

  // Access qualification and address decode
  always_comb begin
    start_s    = bus.as && !rw_state_r && (!bus.rs_n || !bus.ws_n);
    rd_s       = start_s && !bus.rs_n;
    in_range_s = (bus.address < 24'(NUM_REGS));
    // A concurrent write strobe is dropped when the read strobe is also low
    wr_s       = start_s && bus.rs_n && !bus.ws_n && in_range_s;
    idx_s      = bus.address[ADDR_SEL_BITS-1:0];
    mask_s     = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  end

  // Read mux as an OR of one-hot selected words
  always_comb begin
    rdata_s = 32'h0;
    for (int i = 0; i < NUM_LFSR; i++)
      rdata_s = rdata_s | ((idx_s == ADDR_SEL_BITS'(i)) ? lfsr_r[i] : 32'h0);
    rdata_s = rdata_s | ((idx_s == ADDR_SEL_BITS'(CTRL_IDX)) ?
                         {{(32-NUM_LFSR){1'b0}}, ctrl_r} : 32'h0);
    rdata_s = rdata_s | ((idx_s == ADDR_SEL_BITS'(CNT_IDX)) ? cnt_r : 32'h0);
    for (int i = 0; i < NUM_SCR; i++)
      rdata_s = rdata_s | ((idx_s == ADDR_SEL_BITS'(SCR_BASE + i)) ? scr_r[i] : 32'h0);
  end

  // Next-state of every storage element
  always_comb begin
    for (int i = 0; i < NUM_LFSR; i++) begin
      lfsr_nx_s[i] = lfsr_r[i];
      if (wr_s && idx_s == ADDR_SEL_BITS'(i)) begin
        lfsr_nx_s[i] = byte_merge(lfsr_r[i], bus.data_in, mask_s);
        if (lfsr_nx_s[i] == 32'h0) lfsr_nx_s[i] = LFSR_SEED;
        else                       lfsr_nx_s[i] = lfsr_nx_s[i];
      end else if ((rd_s && in_range_s && idx_s == ADDR_SEL_BITS'(i)) || ctrl_r[i]) begin
        lfsr_nx_s[i] = lfsr_step(lfsr_r[i]);
      end else begin
        lfsr_nx_s[i] = lfsr_r[i];
      end
    end

    if (wr_s && idx_s == ADDR_SEL_BITS'(CTRL_IDX))
      ctrl_nx_s = (ctrl_r & ~mask_s[NUM_LFSR-1:0]) |
                  (bus.data_in[NUM_LFSR-1:0] & mask_s[NUM_LFSR-1:0]);
    else
      ctrl_nx_s = ctrl_r;

    // A write to the counter clears it and is itself not counted
    if (wr_s && idx_s == ADDR_SEL_BITS'(CNT_IDX)) cnt_nx_s = 32'h0;
    else if (start_s)                             cnt_nx_s = cnt_r + 32'h1;
    else                                          cnt_nx_s = cnt_r;

    for (int i = 0; i < NUM_SCR; i++) begin
      if (wr_s && idx_s == ADDR_SEL_BITS'(SCR_BASE + i))
        scr_nx_s[i] = byte_merge(scr_r[i], bus.data_in, mask_s);
      else
        scr_nx_s[i] = scr_r[i];
    end
  end

  // State registers, registered read data and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_state_r <= 1'b0;
      data_out_r <= RESET_DATA;
      err_r      <= 1'b0;
      ctrl_r     <= '0;
      cnt_r      <= 32'h0;
      for (int i = 0; i < NUM_LFSR; i++) lfsr_r[i] <= LFSR_SEED + 32'(i);
      for (int i = 0; i < NUM_SCR; i++)  scr_r[i]  <= 32'h0;
    end else begin
      if (start_s)      rw_state_r <= 1'b1;
      else if (!bus.as) rw_state_r <= 1'b0;
      else              rw_state_r <= rw_state_r;
      if (rd_s) data_out_r <= in_range_s ? rdata_s : 32'h0;
      else      data_out_r <= data_out_r;
      err_r  <= start_s && !in_range_s;
      ctrl_r <= ctrl_nx_s;
      cnt_r  <= cnt_nx_s;
      for (int i = 0; i < NUM_LFSR; i++) lfsr_r[i] <= lfsr_nx_s[i];
      for (int i = 0; i < NUM_SCR; i++)  scr_r[i]  <= scr_nx_s[i];
    end
  end
endmodule

// File: tb/tb_reg_file_multi.sv
// Directed bench for reg_file_multi: a word-level reference model is checked every cycle,
// and hand-computed literals pin key results.
module tb_reg_file_multi;
  localparam int          NL   = 2;
  localparam int          NR   = 8;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [31:0] SEED = 32'h00000001;
  localparam logic [31:0] RSTD = 32'hfee1dead;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_multi_if ifc();

  reg_file_multi #(
    .NUM_REGS(NR), .ADDR_SEL_BITS(3), .NUM_LFSR(NL),
    .LFSR_POLY(POLY), .LFSR_SEED(SEED), .RESET_DATA(RSTD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one array per register kind, indexed by word address
  logic [31:0] m_lfsr[NL];
  logic [31:0] m_mem[NR];
  logic [31:0] m_ctrl, m_cnt, exp_dout;
  logic        m_busy, exp_err, m_valid = 1'b0;
  logic        m_start, m_rd, m_wr;
  int          m_a;

  assign m_a     = int'(ifc.address);
  assign m_start = ifc.as && !m_busy && (!ifc.rs_n || !ifc.ws_n);
  assign m_rd    = m_start && !ifc.rs_n;
  assign m_wr    = m_start && ifc.rs_n && !ifc.ws_n;

  function automatic logic [31:0] step_f(input logic [31:0] r);
    if (r[0]) return (r >> 1) ^ POLY;
    else      return r >> 1;
  endfunction

  function automatic logic [31:0] merge_f(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] b);
    logic [31:0] v;
    v = old_v;
    for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = d[8*k +: 8];
    return v;
  endfunction

  function automatic logic [31:0] read_f(input int a);
    if (a < NL)      return m_lfsr[a];
    if (a == NL)     return m_ctrl;
    if (a == NL + 1) return m_cnt;
    if (a < NR)      return m_mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] lfsr_next_f(input int i);
    logic [31:0] v;
    if (m_wr && m_a == i) begin
      v = merge_f(m_lfsr[i], ifc.data_in, ifc.be);
      return (v == 32'h0) ? SEED : v;
    end
    if ((m_rd && m_a == i) || m_ctrl[i]) return step_f(m_lfsr[i]);
    return m_lfsr[i];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) m_lfsr[i] <= SEED + 32'(i);
      for (int a = 0; a < NR; a++) m_mem[a] <= 32'h0;
      m_ctrl   <= 32'h0;
      m_cnt    <= 32'h0;
      m_busy   <= 1'b0;
      exp_dout <= RSTD;
      exp_err  <= 1'b0;
      m_valid  <= 1'b1;
    end else begin
      for (int i = 0; i < NL; i++) m_lfsr[i] <= lfsr_next_f(i);
      if (m_start) begin
        m_busy  <= 1'b1;
        exp_err <= (m_a >= NR);
        if (m_rd) exp_dout <= read_f(m_a);
        if (m_wr && m_a == NL)
          m_ctrl <= merge_f(m_ctrl, ifc.data_in, ifc.be) & ((32'h1 << NL) - 32'h1);
        if (m_wr && m_a == NL + 1) m_cnt <= 32'h0;
        else                       m_cnt <= m_cnt + 32'h1;
        if (m_wr && m_a > NL + 1 && m_a < NR)
          m_mem[m_a] <= merge_f(m_mem[m_a], ifc.data_in, ifc.be);
      end else begin
        exp_err <= 1'b0;
        if (!ifc.as) m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("data_out", ifc.data_out, exp_dout);
      check("err", {31'h0, ifc.err}, {31'h0, exp_err});
    end
  end

  task automatic idle(input int n);
    ifc.as = 1'b0; ifc.rs_n = 1'b1; ifc.ws_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [23:0] a);
    ifc.address = a; ifc.rs_n = 1'b0; ifc.ws_n = 1'b1; ifc.as = 1'b1;
    @(negedge clk);
    idle(1);
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] b);
    ifc.address = a; ifc.data_in = d; ifc.be = b;
    ifc.rs_n = 1'b1; ifc.ws_n = 1'b0; ifc.as = 1'b1;
    @(negedge clk);
    idle(1);
  endtask

  initial begin
    ifc.address = 24'h0; ifc.data_in = 32'h0; ifc.be = 4'h0;
    ifc.as = 1'b0; ifc.rs_n = 1'b1; ifc.ws_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("reset data_out", ifc.data_out, 32'hfee1dead);
    check("reset err", {31'h0, ifc.err}, 32'h0);
    check("model reset", exp_dout, 32'hfee1dead);

    rd(24'd0); check("lfsr0 read1", ifc.data_out, 32'h00000001);
    rd(24'd0); check("lfsr0 read2", ifc.data_out, 32'h80200003);
    rd(24'd0); check("lfsr0 read3", ifc.data_out, 32'hc0300002);
    check("model lfsr0 read3", exp_dout, 32'hc0300002);

    // Strobe held for six cycles: a single access only
    ifc.address = 24'd1; ifc.rs_n = 1'b0; ifc.as = 1'b1;
    repeat (6) @(negedge clk);
    idle(1);
    check("held read lfsr1", ifc.data_out, 32'h00000002);
    rd(24'd1); check("lfsr1 one step", ifc.data_out, 32'h00000001);
    rd(24'd3); check("access count", ifc.data_out, 32'h00000005);

    wr(24'd4, 32'haabbccdd, 4'b0101);
    rd(24'd4); check("scratch merge", ifc.data_out, 32'h00bb00dd);
    wr(24'd0, 32'h0, 4'hf);
    rd(24'd0); check("lfsr zero write", ifc.data_out, 32'h00000001);
    wr(24'd5, 32'h12345678, 4'h0);
    rd(24'd5); check("be zero write", ifc.data_out, 32'h00000000);
    wr(24'd3, 32'hdeadbeef, 4'hf);
    rd(24'd3); check("count cleared", ifc.data_out, 32'h00000000);

    // Both strobes low: read wins, write dropped
    ifc.address = 24'd4; ifc.data_in = 32'hffffffff; ifc.be = 4'hf;
    ifc.rs_n = 1'b0; ifc.ws_n = 1'b0; ifc.as = 1'b1;
    @(negedge clk);
    idle(1);
    check("read wins", ifc.data_out, 32'h00bb00dd);
    rd(24'd4); check("write discarded", ifc.data_out, 32'h00bb00dd);

    wr(24'd2, 32'hffffffff, 4'hf);
    rd(24'd2); check("ctrl masked", ifc.data_out, 32'h00000003);
    idle(3);
    rd(24'd0);
    rd(24'd1);
    wr(24'd2, 32'h0, 4'hf);
    idle(2);

    ifc.address = 24'd8; ifc.rs_n = 1'b0; ifc.as = 1'b1;
    @(negedge clk);
    check("oor read data", ifc.data_out, 32'h0);
    check("oor read err", {31'h0, ifc.err}, 32'h1);
    idle(1);
    check("oor err one cycle", {31'h0, ifc.err}, 32'h0);
    wr(24'h000100, 32'h55555555, 4'hf);
    rd(24'd3);
    rd(24'd4); check("oor write no change", ifc.data_out, 32'h00bb00dd);

    // Reset during a held read, then a fresh access on release
    ifc.address = 24'd0; ifc.rs_n = 1'b0; ifc.as = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset data_out", ifc.data_out, 32'hfee1dead);
    rst_n = 1'b1;
    @(negedge clk);
    check("read after reset", ifc.data_out, 32'h00000001);
    idle(1);
    rd(24'd3); check("count after reset", ifc.data_out, 32'h00000001);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
